// File: rtl/seg7_scan_driver_pkg.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver_pkg
// Shared constants and helpers for the time-multiplexed 7-segment driver.
//   NUM_DIGITS    : number of scanned digits
//   SEG_BLANK     : active-low cathode pattern with every segment dark
//   AN_OFF        : active-low anode pattern with every digit disabled
//   HEX_SEG_TABLE : hex nibble -> {g,f,e,d,c,b,a}, active-low
//   digit_enable  : active-low anode pattern selecting one digit
//   lead_zero     : true when the nibbles from a digit up to the top are zero
// ---------------------------------------------------------------------------
package seg7_scan_driver_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

    localparam logic [6:0]            SEG_BLANK = 7'b1111111;
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'b1111;

    // Entry [n] is the pattern for nibble n (entry 15 is listed first).
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Active-low one-cold anode pattern for a digit index.
    function automatic logic [NUM_DIGITS-1:0] digit_enable(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

    // A digit is a leading zero when it and every more significant nibble
    // are zero. Digit 0 never qualifies so a zero value still shows "0".
    function automatic logic lead_zero(input logic [15:0] value, input digit_idx_t idx);
        logic result;
        case (idx)
            2'd3:    result = (value[15:12] == 4'h0);
            2'd2:    result = (value[15:8]  == 8'h00);
            2'd1:    result = (value[15:4]  == 12'h000);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundles the display value/control inputs and the display pin outputs.
//   data_in    : 16-bit value, digit 0 (rightmost) = data_in[3:0]
//   blank      : 1 = all digits dark, scanning continues
//   lz_en      : 1 = suppress leading zero digits
//   dp_in      : per-digit decimal point request, active-high
//   an         : digit enables, active-low, an[0] = rightmost
//   seg        : cathodes {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point cathode, active-low
//   frame_tick : one-clock pulse when a new frame is latched
// master drives the value/control side, slave is the driver itself.
// ---------------------------------------------------------------------------
interface seg7_scan_driver_if;

    logic [15:0] data_in;
    logic        blank;
    logic        lz_en;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport master (
        output data_in, blank, lz_en, dp_in,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  data_in, blank, lz_en, dp_in,
        output an, seg, dp, frame_tick
    );

endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
// Purely combinational hex nibble to active-low 7-segment decoder.
//   nibble : 4-bit value to show
//   seg_n  : cathodes {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module hex_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Table lookup of the segment pattern.
    always_comb begin
        seg_n = HEX_SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Shows a 16-bit value as four hex digits on a common-anode, time-multiplexed
// 7-segment display. A prescaler produces one tick every REFRESH_DIV clocks;
// each tick advances the scanned digit and reloads an/seg/dp together. The
// value is snapshotted at the start of every frame so digits never tear.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   bus   : value/control inputs and display outputs (slave modport)
// Parameters:
//   REFRESH_DIV : clocks per digit slot (2..2^20)
//   CNT_W       : prescaler width, 2^CNT_W >= REFRESH_DIV
// ---------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 20
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);

    localparam logic [CNT_W-1:0] PRESCALE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] PRESCALE_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]      prescaler_q, prescaler_d;
    digit_idx_t            digit_idx_q, digit_idx_d;
    logic [15:0]           snapshot_q,  snapshot_d;
    logic [NUM_DIGITS-1:0] an_q,        an_d;
    logic [6:0]            seg_q,       seg_d;
    logic                  dp_q,        dp_d;
    logic                  frame_tick_q, frame_tick_d;

    logic       tick_s;
    digit_idx_t next_idx_s;
    logic [3:0] nibble_s;
    logic [6:0] dec_seg_s;
    logic       blank_digit_s;

    // Prescaler terminal count and the index the next tick will select.
    always_comb begin
        tick_s     = (prescaler_q == PRESCALE_LAST);
        next_idx_s = digit_idx_q + 2'd1;
    end

    // Nibble for the digit being loaded. Digit 0 is loaded on the same edge
    // that latches the snapshot, so it reads data_in directly; the other
    // digits read the snapshot that edge captured.
    always_comb begin
        case (next_idx_s)
            2'd0:    nibble_s = bus.data_in[3:0];
            2'd1:    nibble_s = snapshot_q[7:4];
            2'd2:    nibble_s = snapshot_q[11:8];
            2'd3:    nibble_s = snapshot_q[15:12];
            default: nibble_s = bus.data_in[3:0];
        endcase
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble_s),
        .seg_n  (dec_seg_s)
    );

    // A slot is dark when globally blanked or when it is a suppressed
    // leading zero of the current snapshot.
    always_comb begin
        blank_digit_s = bus.blank | (bus.lz_en & lead_zero(snapshot_q, next_idx_s));
    end

    // Next-state logic: prescaler, scan index, frame latch and output reload.
    always_comb begin
        prescaler_d  = prescaler_q;
        digit_idx_d  = digit_idx_q;
        snapshot_d   = snapshot_q;
        an_d         = an_q;
        seg_d        = seg_q;
        dp_d         = dp_q;
        frame_tick_d = 1'b0;

        if (tick_s) begin
            prescaler_d = '0;
            digit_idx_d = next_idx_s;

            // an, seg and dp reload together so no digit shows a stale pattern.
            if (blank_digit_s) begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
                dp_d  = 1'b1;
            end else begin
                an_d  = digit_enable(next_idx_s);
                seg_d = dec_seg_s;
                dp_d  = ~bus.dp_in[next_idx_s];
            end

            if (next_idx_s == 2'd0) begin
                snapshot_d   = bus.data_in;
                frame_tick_d = 1'b1;
            end else begin
                snapshot_d   = snapshot_q;
                frame_tick_d = 1'b0;
            end
        end else begin
            prescaler_d = prescaler_q + PRESCALE_ONE;
        end
    end

    // State and output registers; reset leaves every digit dark and starts
    // at index 3 so the first tick begins a frame at digit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler_q  <= '0;
            digit_idx_q  <= 2'd3;
            snapshot_q   <= 16'h0000;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            digit_idx_q  <= digit_idx_d;
            snapshot_q   <= snapshot_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with REFRESH_DIV=4 (16-clock frames).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    seg7_scan_driver_if u_if ();

    seg7_scan_driver #(
        .REFRESH_DIV (4),
        .CNT_W       (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reset held: all outputs in reset state; release on a falling edge.
    task automatic test_reset;
        u_if.data_in = 16'h1234;
        u_if.blank   = 1'b0;
        u_if.lz_en   = 1'b0;
        u_if.dp_in   = 4'b0000;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (u_if.an !== 4'b1111) $display("FAIL reset_an: got %b expected 1111", u_if.an);
        else pass_cnt++;
        total_cnt++;
        if (u_if.seg !== 7'b1111111) $display("FAIL reset_seg: got %b expected 1111111", u_if.seg);
        else pass_cnt++;
        total_cnt++;
        if (u_if.dp !== 1'b1) $display("FAIL reset_dp: got %b expected 1", u_if.dp);
        else pass_cnt++;
        total_cnt++;
        if (u_if.frame_tick !== 1'b0) $display("FAIL reset_ft: got %b expected 0", u_if.frame_tick);
        else pass_cnt++;
        rst = 1'b1;
    endtask

    // First frame after release: 3 dark samples, then digits 4,3,2,1.
    task automatic test_startup;
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        logic       exp_ft;
        exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total_cnt++;
            if (u_if.an !== 4'b1111 || u_if.frame_tick !== 1'b0)
                $display("FAIL startup_dark k=%0d: got an=%b ft=%b expected an=1111 ft=0",
                         k, u_if.an, u_if.frame_tick);
            else pass_cnt++;
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << (k / 4));
            exp_ft = (k == 0);
            total_cnt++;
            if (u_if.an !== exp_an || u_if.seg !== exp_seg[k / 4] || u_if.dp !== 1'b1)
                $display("FAIL startup_slot k=%0d: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=1",
                         k, u_if.an, u_if.seg, u_if.dp, exp_an, exp_seg[k / 4]);
            else pass_cnt++;
            total_cnt++;
            if (u_if.frame_tick !== exp_ft)
                $display("FAIL startup_ft k=%0d: got %b expected %b", k, u_if.frame_tick, exp_ft);
            else pass_cnt++;
        end
    endtask

    // data_in changes while digit 2 is lit: old frame finishes, next shows new.
    task automatic test_data_change;
        logic [6:0] exp_seg [8];
        logic [3:0] exp_an;
        logic       exp_ft;
        exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001,
                    7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000};
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            exp_ft = (k % 16 == 0);
            total_cnt++;
            if (u_if.frame_tick !== exp_ft)
                $display("FAIL change_ft k=%0d: got %b expected %b", k, u_if.frame_tick, exp_ft);
            else pass_cnt++;
            if (k % 4 == 1) begin
                exp_an = ~(4'b0001 << ((k / 4) % 4));
                total_cnt++;
                if (u_if.an !== exp_an || u_if.seg !== exp_seg[k / 4])
                    $display("FAIL change_slot k=%0d: got an=%b seg=%b expected an=%b seg=%b",
                             k, u_if.an, u_if.seg, exp_an, exp_seg[k / 4]);
                else pass_cnt++;
            end
            if (k == 9) u_if.data_in = 16'hABCD;
        end
    endtask

    // Leading-zero suppression for 0000 then 00F0.
    task automatic test_lz;
        logic [3:0] exp_an  [8];
        logic [6:0] exp_seg [8];
        exp_an  = '{4'b1110, 4'b1111, 4'b1111, 4'b1111,
                    4'b1110, 4'b1101, 4'b1111, 4'b1111};
        exp_seg = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111,
                    7'b1000000, 7'b0001110, 7'b1111111, 7'b1111111};
        u_if.lz_en   = 1'b1;
        u_if.data_in = 16'h0000;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (k % 4 == 1) begin
                total_cnt++;
                if (u_if.an !== exp_an[k / 4] || u_if.seg !== exp_seg[k / 4])
                    $display("FAIL lz_slot k=%0d: got an=%b seg=%b expected an=%b seg=%b",
                             k, u_if.an, u_if.seg, exp_an[k / 4], exp_seg[k / 4]);
                else pass_cnt++;
            end
            if (k == 3) u_if.data_in = 16'h00F0;
        end
        u_if.lz_en = 1'b0;
    endtask

    // Decimal points on digits 0 and 2 with all-eights.
    task automatic test_dp;
        logic exp_dp [4];
        exp_dp = '{1'b0, 1'b1, 1'b0, 1'b1};
        u_if.dp_in   = 4'b0101;
        u_if.data_in = 16'h8888;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k % 4 == 1) begin
                total_cnt++;
                if (u_if.seg !== 7'b0000000 || u_if.dp !== exp_dp[k / 4]
                    || u_if.an !== ~(4'b0001 << (k / 4)))
                    $display("FAIL dp_slot k=%0d: got an=%b seg=%b dp=%b expected seg=0000000 dp=%b",
                             k, u_if.an, u_if.seg, u_if.dp, exp_dp[k / 4]);
                else pass_cnt++;
            end
        end
        u_if.dp_in = 4'b0000;
    endtask

    // blank asserted mid-frame, frame_tick keeps running, release restores.
    task automatic test_blank;
        logic [3:0] exp_an  [8];
        logic [6:0] exp_seg [8];
        logic       exp_dp  [8];
        logic       exp_ft;
        exp_an  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111,
                    4'b1111, 4'b1111, 4'b1011, 4'b0111};
        exp_seg = '{7'b0011001, 7'b0110000, 7'b1111111, 7'b1111111,
                    7'b1111111, 7'b1111111, 7'b0100100, 7'b1111001};
        exp_dp  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        u_if.data_in = 16'h1234;
        u_if.dp_in   = 4'b1111;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            exp_ft = (k % 16 == 0);
            total_cnt++;
            if (u_if.frame_tick !== exp_ft)
                $display("FAIL blank_ft k=%0d: got %b expected %b", k, u_if.frame_tick, exp_ft);
            else pass_cnt++;
            if (k % 4 == 1) begin
                total_cnt++;
                if (u_if.an !== exp_an[k / 4] || u_if.seg !== exp_seg[k / 4]
                    || u_if.dp !== exp_dp[k / 4])
                    $display("FAIL blank_slot k=%0d: got an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                             k, u_if.an, u_if.seg, u_if.dp,
                             exp_an[k / 4], exp_seg[k / 4], exp_dp[k / 4]);
                else pass_cnt++;
            end
            if (k == 5)  u_if.blank = 1'b1;
            if (k == 21) u_if.blank = 1'b0;
        end
        u_if.dp_in = 4'b0000;
    endtask

    // Asynchronous reset in the middle of a slot, then release.
    task automatic test_async_reset;
        u_if.data_in = 16'h1234;
        repeat (6) @(negedge clk);
        total_cnt++;
        if (u_if.an !== 4'b1101) $display("FAIL async_pre_an: got %b expected 1101", u_if.an);
        else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (u_if.an !== 4'b1111 || u_if.seg !== 7'b1111111 || u_if.dp !== 1'b1
            || u_if.frame_tick !== 1'b0)
            $display("FAIL async_now: got an=%b seg=%b dp=%b ft=%b expected 1111 1111111 1 0",
                     u_if.an, u_if.seg, u_if.dp, u_if.frame_tick);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (u_if.an !== 4'b1111 || u_if.seg !== 7'b1111111)
            $display("FAIL async_held: got an=%b seg=%b expected 1111 1111111", u_if.an, u_if.seg);
        else pass_cnt++;
        rst = 1'b1;
    endtask

    initial begin
        u_if.data_in = 16'h0000;
        u_if.blank   = 1'b0;
        u_if.lz_en   = 1'b0;
        u_if.dp_in   = 4'b0000;
        test_reset();
        test_startup();
        test_data_change();
        test_lz();
        test_dp();
        test_blank();
        test_async_reset();
        test_startup();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
